// File: rtl/echo_multitap.sv
// echo_multitap: N-tap delay/echo processor on a single signed sample stream.
//
// One sample is accepted per in_valid strobe while idle. Each tap reads the
// delay line at (wr_ptr - offset), is attenuated by an arithmetic right shift,
// and is summed into a wide accumulator. The saturated mix is presented on out.
// The sample, with optional attenuated tap-sum feedback, is then written back
// at wr_ptr. The delay line is one single-port RAM, zeroed after every reset.
//
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   enable      1 = echo mix, 0 = dry passthrough (delay line still written)
//   in_valid    one-cycle strobe qualifying in
//   in          signed input sample
//   tap_offset  per-tap delay in samples, tap i at [i*DEPTH_LOG2 +: DEPTH_LOG2]
//   tap_shift   per-tap attenuation shift, 4'hF mutes the tap
//   fb_enable   feed the tap-sum back into the delay line
//   fb_shift    feedback attenuation shift, 4'hF disables feedback
//   out         signed mixed output, held between updates
//   out_valid   one-cycle strobe, out updated
//   busy        high while clearing or processing a sample
//   overrun     sticky, in_valid arrived while busy
module echo_multitap #(
  parameter int unsigned BITSIZE    = 16,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned NTAPS      = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          in_valid,
  input  logic signed [BITSIZE-1:0]     in,
  input  logic [NTAPS*DEPTH_LOG2-1:0]   tap_offset,
  input  logic [NTAPS*4-1:0]            tap_shift,
  input  logic                          fb_enable,
  input  logic [3:0]                    fb_shift,
  output logic signed [BITSIZE-1:0]     out,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  // Sum of NTAPS full-scale taps fits BITSIZE + clog2(NTAPS); one guard bit on top.
  localparam int unsigned ACCW  = BITSIZE + $clog2(NTAPS) + 1;
  // Sample plus accumulator needs one more bit before saturation.
  localparam int unsigned SUMW  = ACCW + 1;
  localparam int unsigned IDXW  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IDXW-1:0] LastIdx = IDXW'(NTAPS - 1);

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StRead,
    StAcc,
    StWrite
  } state_e;

  state_e                      state_q;
  logic [DEPTH_LOG2-1:0]       clr_cnt_q;
  logic [DEPTH_LOG2-1:0]       wr_ptr_q;
  logic [IDXW-1:0]             rd_idx_q;
  logic signed [ACCW-1:0]      acc_q;
  logic signed [BITSIZE-1:0]   in_q;
  logic [DEPTH_LOG2-1:0]       offs_q [NTAPS];
  logic [3:0]                  shift_q [NTAPS];
  logic                        fb_en_q;
  logic [3:0]                  fb_shift_q;
  logic                        enable_q;
  logic signed [BITSIZE-1:0]   wdata_q;

  // Delay line RAM signals.
  logic                        ram_we;
  logic [DEPTH_LOG2-1:0]       ram_addr;
  logic signed [BITSIZE-1:0]   ram_wdata;
  logic signed [BITSIZE-1:0]   ram_rdata;
  logic signed [BITSIZE-1:0]   mem [DEPTH];

  // Datapath.
  logic [IDXW-1:0]             tap_sel;
  logic [3:0]                  tap_sh;
  logic signed [BITSIZE-1:0]   tap_shifted;
  logic signed [ACCW-1:0]      tap_term;
  logic signed [ACCW-1:0]      acc_next;
  logic signed [ACCW-1:0]      acc_fb;
  logic signed [SUMW-1:0]      in_ext;
  logic signed [SUMW-1:0]      acc_ext;
  logic signed [SUMW-1:0]      fb_ext;
  logic signed [SUMW-1:0]      mix_sum;
  logic signed [SUMW-1:0]      fb_sum;
  logic signed [BITSIZE-1:0]   mix;
  logic signed [BITSIZE-1:0]   fb_val;

  // Clamp a wide signed sum into the sample range.
  function automatic logic signed [BITSIZE-1:0] sat(input logic signed [SUMW-1:0] v);
    if (v[SUMW-1:BITSIZE-1] == {(SUMW-BITSIZE+1){v[SUMW-1]}}) begin
      return v[BITSIZE-1:0];
    end else if (v[SUMW-1]) begin
      return {1'b1, {(BITSIZE-1){1'b0}}};
    end else begin
      return {1'b0, {(BITSIZE-1){1'b1}}};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Single-port delay line, read-before-write, one cycle read latency.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = wr_ptr_q;
    ram_wdata = '0;
    unique case (state_q)
      StClear: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt_q;
      end
      // Offset 0 lands on wr_ptr itself, which still holds the oldest sample.
      StRead:  ram_addr = wr_ptr_q - offs_q[rd_idx_q];
      StWrite: begin
        ram_we    = 1'b1;
        ram_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tap accumulation. Read data arriving now belongs to the tap addressed in
  // the previous cycle: rd_idx-1 during READ, the last tap during ACC.
  // ---------------------------------------------------------------------------
  always_comb begin
    tap_sel     = (state_q == StAcc) ? LastIdx : rd_idx_q - IDXW'(1);
    tap_sh      = shift_q[tap_sel];
    tap_shifted = ram_rdata >>> tap_sh;
    if (tap_sh == 4'hF) begin
      tap_term = '0;
    end else begin
      tap_term = {{(ACCW-BITSIZE){tap_shifted[BITSIZE-1]}}, tap_shifted};
    end
    acc_next = acc_q + tap_term;
  end

  // Mix and feedback values, both saturated, consumed at the end of ACC.
  always_comb begin
    in_ext  = {{(SUMW-BITSIZE){in_q[BITSIZE-1]}}, in_q};
    acc_ext = {{(SUMW-ACCW){acc_next[ACCW-1]}}, acc_next};
    acc_fb  = acc_next >>> fb_shift_q;
    fb_ext  = {{(SUMW-ACCW){acc_fb[ACCW-1]}}, acc_fb};
    mix_sum = in_ext + acc_ext;
    fb_sum  = in_ext + fb_ext;
    mix     = enable_q ? sat(mix_sum) : in_q;
    fb_val  = (fb_en_q && (fb_shift_q != 4'hF)) ? sat(fb_sum) : in_q;
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_idx_q   <= '0;
      acc_q      <= '0;
      in_q       <= '0;
      fb_en_q    <= 1'b0;
      fb_shift_q <= 4'hF;
      enable_q   <= 1'b0;
      wdata_q    <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b1;
      overrun    <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        offs_q[i]  <= '0;
        shift_q[i] <= 4'hF;
      end
    end else begin
      out_valid <= 1'b0;
      if (in_valid && (state_q != StIdle)) begin
        overrun <= 1'b1;
      end

      unique case (state_q)
        StClear: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end

        StIdle: begin
          if (in_valid) begin
            in_q       <= in;
            fb_en_q    <= fb_enable;
            fb_shift_q <= fb_shift;
            enable_q   <= enable;
            for (int i = 0; i < NTAPS; i++) begin
              offs_q[i]  <= tap_offset[i*DEPTH_LOG2 +: DEPTH_LOG2];
              shift_q[i] <= tap_shift[i*4 +: 4];
            end
            rd_idx_q <= '0;
            acc_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StRead;
          end
        end

        StRead: begin
          if (rd_idx_q != '0) begin
            acc_q <= acc_next;
          end
          if (rd_idx_q == LastIdx) begin
            state_q <= StAcc;
          end else begin
            rd_idx_q <= rd_idx_q + 1'b1;
          end
        end

        StAcc: begin
          out       <= mix;
          wdata_q   <= fb_val;
          out_valid <= 1'b1;
          state_q   <= StWrite;
        end

        StWrite: begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end

        default: begin
          state_q <= StClear;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule
